// File: rtl/biquad8_ctrl_pkg.sv
// biquad8_ctrl_pkg: shared biquad8 control register map and coefficient loader types
package biquad8_ctrl_pkg;
    localparam logic [6:0] ADR_UPDATE       = 7'h00;
    localparam logic [6:0] ADR_FIR          = 7'h04;
    localparam logic [6:0] ADR_IIR          = 7'h08;
    localparam logic [6:0] ADR_INC          = 7'h0C;
    localparam logic [6:0] ADR_POLEFIR_BASE = 7'h10;
    localparam int TBL_W = 25;
    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_LOAD, ST_WRITE, ST_UPDATE, ST_DONE, ST_ABORT
    } loader_state_t;
    typedef enum logic [1:0] {
        ERR_NONE = 2'b00, ERR_WB = 2'b01, ERR_TIMEOUT = 2'b10
    } err_code_t;
endpackage

// File: rtl/biquad8_coeff_table.sv
// biquad8_coeff_table: DEPTH x 25 single-port coefficient RAM with registered read
module biquad8_coeff_table
    import biquad8_ctrl_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             wb_clk_i,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [AW-1:0]    adr,
    input  logic [TBL_W-1:0] wdat,
    output logic [TBL_W-1:0] rdat
);
    logic [TBL_W-1:0] mem [DEPTH];
    always_ff @(posedge wb_clk_i) begin
        if (wr_en) mem[adr] <= wdat;
        if (rd_en) rdat <= mem[adr];
    end
endmodule

// File: rtl/biquad8_coeff_loader.sv
// biquad8_coeff_loader: WISHBONE initiator replaying a coefficient table into one biquad8 target
// Optional BIQUAD8_LOADER_TIMEOUT_EN aborts a write left unanswered for TIMEOUT_CYCLES.
module biquad8_coeff_loader
    import biquad8_ctrl_pkg::*;
#(
    parameter int DEPTH          = 32,
    parameter int AW             = $clog2(DEPTH),
    parameter bit UPDATE_AT_END  = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [6:0]       wb_adr_o,
    output logic [31:0]      wb_dat_o,
    output logic [3:0]       wb_sel_o,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic             wb_rty_i,
    input  logic             tbl_wr_i,
    input  logic [AW-1:0]    tbl_adr_i,
    input  logic [TBL_W-1:0] tbl_dat_i,
    input  logic             start_i,
    input  logic [AW:0]      nent_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       err_code_o
);
    loader_state_t    state;
    logic [AW-1:0]    idx;
    logic [AW:0]      nent, idx_nxt;
    logic [TBL_W-1:0] rd_dat;
    logic             gap, last, tmo;
    logic             unused_adr_lsb;
    assign wb_we_o = wb_cyc_o;
    assign wb_sel_o = 4'hF;
    assign idx_nxt = {1'b0, idx} + (AW+1)'(1);
    assign last = idx_nxt == nent;
    assign unused_adr_lsb = ^rd_dat[19:18];
    biquad8_coeff_table #(.DEPTH(DEPTH), .AW(AW)) u_table (
        .wb_clk_i (wb_clk_i),
        .wr_en    (tbl_wr_i && !busy_o),
        .rd_en    (state == ST_FETCH),
        .adr      (busy_o ? idx : tbl_adr_i),
        .wdat     (tbl_dat_i),
        .rdat     (rd_dat)
    );
`ifdef BIQUAD8_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    always_ff @(posedge wb_clk_i) begin
        tmo_cnt <= (!wb_rst_ni || !wb_stb_o) ? '0 : tmo_cnt + TW'(1);
    end
    assign tmo = wb_stb_o && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
    logic unused_tmo;
    assign unused_tmo = TIMEOUT_CYCLES == 0;
    assign tmo = 1'b0;
`endif
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state      <= ST_IDLE;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
            idx        <= '0;
            nent       <= '0;
            gap        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: if (start_i) begin
                    busy_o     <= 1'b1;
                    err_o      <= 1'b0;
                    err_code_o <= ERR_NONE;
                    idx        <= '0;
                    nent       <= nent_i;
                    gap        <= 1'b1;
                    state      <= nent_i != '0 ? ST_FETCH : UPDATE_AT_END ? ST_UPDATE : ST_DONE;
                end
                ST_FETCH: state <= ST_LOAD;
                ST_LOAD: begin
                    wb_adr_o <= {rd_dat[24:20], 2'b00};
                    wb_dat_o <= {14'b0, rd_dat[17:0]};
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    state    <= ST_WRITE;
                end
                // gap delays the update strobe so it keeps two idle cycles like table writes
                ST_UPDATE: if (!wb_cyc_o) begin
                    gap <= 1'b0;
                    if (!gap) begin
                        wb_adr_o <= ADR_UPDATE;
                        wb_dat_o <= 32'h1;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                ST_ABORT: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: ;
            endcase
            if (wb_stb_o) begin
                if (wb_err_i || tmo) begin
                    wb_cyc_o   <= 1'b0;
                    wb_stb_o   <= 1'b0;
                    err_o      <= 1'b1;
                    err_code_o <= wb_err_i ? ERR_WB : ERR_TIMEOUT;
                    state      <= ST_ABORT;
                end else if (wb_rty_i) begin
                    wb_stb_o <= 1'b0;
                end else if (wb_ack_i) begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    idx      <= idx_nxt[AW-1:0];
                    gap      <= 1'b1;
                    state    <= (state == ST_UPDATE || (last && !UPDATE_AT_END)) ? ST_DONE :
                                last ? ST_UPDATE : ST_FETCH;
                end
            end else if (wb_cyc_o) begin
                wb_stb_o <= 1'b1;
            end
        end
    end
endmodule
